// File: rtl/xor_chk_pkg.sv
// Shared types and constants for the XOR gate response checker.
package xor_chk_pkg;

  // Checker run state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  // All four {a,b} input combinations observed.
  localparam logic [3:0] COV_ALL = 4'hF;

  // Default parameter values.
  localparam int SETTLE_DEF = 2;
  localparam int CNT_W_DEF  = 16;

  // Reference model of the gate under test.
  function automatic logic expected_y(input logic [1:0] ab);
    return ab[1] ^ ab[0];
  endfunction

endpackage

// File: rtl/xor_resp_checker_if.sv
// Bundle of the checker's control, observed-gate and result signals.
interface xor_resp_checker_if
  import xor_chk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             start;
  logic             a;
  logic             b;
  logic             y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       cov;
  logic             ff_valid;
  logic [1:0]       ff_ab;
  logic             ff_y;

  // Stimulus side: drives start and the gate pins, reads results.
  modport master (
    output start, a, b, y,
    input  busy, done, pass, vec_cnt, err_cnt, cov, ff_valid, ff_ab, ff_y
  );

  // Checker side.
  modport slave (
    input  start, a, b, y,
    output busy, done, pass, vec_cnt, err_cnt, cov, ff_valid, ff_ab, ff_y
  );

endinterface

// File: rtl/xor_chk_settle.sv
// Input-vector stability tracker: raises sample_en_o for exactly one edge
// once a vector has been held SETTLE edges and has not yet been sampled.
module xor_chk_settle
  import xor_chk_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ab_i,
  input  logic       clr_i,       // first edge of a fresh run
  input  logic       en_i,        // sampling permitted on this edge
  output logic       sample_en_o
);

  // Counter is 8 bits wide, enough for SETTLE up to 255.
  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  logic [1:0] ab_q;
  logic [7:0] stab_q;
  logic [7:0] stab_d;
  logic       sampled_q;
  logic       sampled_d;
  logic       changed;

  // Next-state for the stable counter and sampled flag; a change or a
  // fresh run restarts the settle window.
  always_comb begin
    changed     = (ab_i != ab_q);
    stab_d      = stab_q;
    sampled_d   = sampled_q;
    sample_en_o = 1'b0;
    if (changed || clr_i) begin
      stab_d    = 8'd0;
      sampled_d = 1'b0;
    end else begin
      if (stab_q != SETTLE_C) begin
        stab_d = stab_q + 8'd1;
      end
      if (en_i && !sampled_q && (stab_d == SETTLE_C)) begin
        sample_en_o = 1'b1;
        sampled_d   = 1'b1;
      end
    end
  end

  // Register the previous vector, stable count and sampled flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ab_q      <= 2'b00;
      stab_q    <= 8'd0;
      sampled_q <= 1'b0;
    end else begin
      ab_q      <= ab_i;
      stab_q    <= stab_d;
      sampled_q <= sampled_d;
    end
  end

endmodule

// File: rtl/xor_resp_checker.sv
// Response checker for a two-input XOR gate: samples settled vectors,
// counts vectors and mismatches, tracks coverage and the first failure.
module xor_resp_checker
  import xor_chk_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  xor_resp_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  chk_state_e       state_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             clr_q;

  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic             ff_valid_q, ff_valid_d;
  logic [1:0]       ff_ab_q, ff_ab_d;
  logic             ff_y_q, ff_y_d;

  logic [1:0]       ab;
  logic             sample_en;
  logic             settle_en;

  assign ab = {bus.a, bus.b};

  // A start on the same edge always beats a pending sample.
  assign settle_en = (state_q == ARM) && !bus.start;

  xor_chk_settle #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .ab_i       (ab),
    .clr_i      (clr_q),
    .en_i       (settle_en),
    .sample_en_o(sample_en)
  );

  // Run-control FSM with registered busy/done/pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      clr_q <= bus.start;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          if (bus.start) begin
            busy_q <= 1'b1;
          end else if (cov_q == COV_ALL) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0);
          end
        end
        DONE: begin
          if (bus.start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  // Result next-state: clear on start, otherwise record a sample event.
  always_comb begin
    vec_d      = vec_q;
    err_d      = err_q;
    cov_d      = cov_q;
    ff_valid_d = ff_valid_q;
    ff_ab_d    = ff_ab_q;
    ff_y_d     = ff_y_q;
    if (bus.start) begin
      vec_d      = '0;
      err_d      = '0;
      cov_d      = 4'h0;
      ff_valid_d = 1'b0;
      ff_ab_d    = 2'b00;
      ff_y_d     = 1'b0;
    end else if (sample_en) begin
      if (vec_q != CNT_MAX) begin
        vec_d = vec_q + CNT_W'(1);
      end
      cov_d[ab] = 1'b1;
      if (bus.y != expected_y(ab)) begin
        if (err_q != CNT_MAX) begin
          err_d = err_q + CNT_W'(1);
        end
        if (!ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_ab_d    = ab;
          ff_y_d     = bus.y;
        end
      end
    end
  end

  // Result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q      <= '0;
      err_q      <= '0;
      cov_q      <= 4'h0;
      ff_valid_q <= 1'b0;
      ff_ab_q    <= 2'b00;
      ff_y_q     <= 1'b0;
    end else begin
      vec_q      <= vec_d;
      err_q      <= err_d;
      cov_q      <= cov_d;
      ff_valid_q <= ff_valid_d;
      ff_ab_q    <= ff_ab_d;
      ff_y_q     <= ff_y_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.vec_cnt  = vec_q;
  assign bus.err_cnt  = err_q;
  assign bus.cov      = cov_q;
  assign bus.ff_valid = ff_valid_q;
  assign bus.ff_ab    = ff_ab_q;
  assign bus.ff_y     = ff_y_q;

endmodule
